unified_mem_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM (SP_SRAM, 1-cycle read latency) between the core's instruction-fetch port and data-access port.
- Placed between RISCV_TOP and one SP_SRAM instance, replacing the separate I-memory and D-memory.
- Arbitrates per cycle: data wins by default; a bounded-streak counter guarantees fetch progress.
- Issues grants to the core and routes read data back with a valid strobe.

---
 rtl/unified_mem_arbiter.sv | 119 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access; data wins unless a
// fetch has waited MAX_D_STREAK grants. Define UNIFIED_MEM_ARB_PERF_EN for perf counters.
module unified_mem_arbiter #(
  parameter int unsigned AWIDTH       = 12,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_REQ,
  input  logic [31:0]       I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [3:0]        D_BE,
  input  logic [31:0]       D_ADDR,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  typedef enum logic [1:0] {OwnNone, OwnIRd, OwnDRd, OwnDWr} owner_e;

  localparam logic [3:0] StreakMax = 4'(MAX_D_STREAK);

  owner_e     r_owner, w_owner_d;
  logic [3:0] r_streak, w_streak_d;
  logic       w_i_gnt, w_d_gnt;

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{I_ADDR[31:AWIDTH+2], I_ADDR[1:0],
                                D_ADDR[31:AWIDTH+2], D_ADDR[1:0]};

  always_comb begin
    w_d_gnt = !RST && D_REQ && (!I_REQ || (r_streak < StreakMax));
    w_i_gnt = !RST && I_REQ && !w_d_gnt;
  end

  assign I_GNT = w_i_gnt;
  assign D_GNT = w_d_gnt;

  always_comb begin
    MEM_CSN  = 1'b1;
    MEM_WEN  = 1'b1;
    MEM_BE   = 4'b0000;
    MEM_ADDR = '0;
    MEM_DI   = '0;
    if (w_d_gnt) begin
      MEM_CSN  = 1'b0;
      MEM_WEN  = ~D_WE;
      MEM_BE   = D_BE;
      MEM_ADDR = D_ADDR[AWIDTH+1:2];
      MEM_DI   = D_WDATA;
    end else if (w_i_gnt) begin
      MEM_CSN  = 1'b0;
      MEM_ADDR = I_ADDR[AWIDTH+1:2];
    end
  end

  always_comb begin
    w_owner_d = OwnNone;
    if (w_d_gnt) begin
      w_owner_d = D_WE ? OwnDWr : OwnDRd;
    end else if (w_i_gnt) begin
      w_owner_d = OwnIRd;
    end

    // Streak only measures how long a pending fetch has been starved.
    w_streak_d = r_streak;
    if (!I_REQ || w_i_gnt) begin
      w_streak_d = 4'd0;
    end else if (w_d_gnt && (r_streak < StreakMax)) begin
      w_streak_d = r_streak + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_owner  <= OwnNone;
      r_streak <= 4'd0;
    end else begin
      r_owner  <= w_owner_d;
      r_streak <= w_streak_d;
    end
  end

  assign I_RVALID = (r_owner == OwnIRd);
  assign D_RVALID = (r_owner == OwnDRd);
  assign I_RDATA  = I_RVALID ? MEM_DOUT : 32'd0;
  assign D_RDATA  = D_RVALID ? MEM_DOUT : 32'd0;

`ifdef UNIFIED_MEM_ARB_PERF_EN
  logic [31:0] perf_i_grants;
  logic [31:0] perf_d_grants;
  logic [31:0] perf_i_stalls;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_i_grants <= 32'd0;
      perf_d_grants <= 32'd0;
      perf_i_stalls <= 32'd0;
    end else begin
      if (w_i_gnt) perf_i_grants <= perf_i_grants + 32'd1;
      if (w_d_gnt) perf_d_grants <= perf_d_grants + 32'd1;
      if (I_REQ && !w_i_gnt) perf_i_stalls <= perf_i_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter with a behavioural SRAM and reference model.
module tb_unified_mem_arbiter;

  localparam int unsigned AW  = 12;
  localparam int unsigned MAX = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          I_REQ = 1'b0, D_REQ = 1'b0, D_WE = 1'b0;
  logic [31:0]   I_ADDR = '0, D_ADDR = '0, D_WDATA = '0;
  logic [3:0]    D_BE = '0;
  logic          I_GNT, I_RVALID, D_GNT, D_RVALID, MEM_CSN, MEM_WEN;
  logic [31:0]   I_RDATA, D_RDATA, MEM_DI;
  logic [3:0]    MEM_BE;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_DOUT = '0;

  logic [31:0] sram    [2**AW];
  logic [31:0] ref_mem [2**AW];

  int n_checks = 0;
  int n_fails  = 0;

  unified_mem_arbiter #(.AWIDTH(AW), .MAX_D_STREAK(MAX)) dut (
    .CLK(CLK), .RST(RST),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
    .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  // Single-port SRAM, one-cycle read latency, byte-enabled writes.
  always @(posedge CLK) begin
    if (!MEM_CSN) begin
      if (!MEM_WEN) begin
        for (int b = 0; b < 4; b++)
          if (MEM_BE[b]) sram[MEM_ADDR][b*8 +: 8] <= MEM_DI[b*8 +: 8];
      end else begin
        MEM_DOUT <= sram[MEM_ADDR];
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    I_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0; D_BE = 4'h0;
    I_ADDR = '0; D_ADDR = '0; D_WDATA = '0;
  endtask

  task automatic test_reset();
    I_REQ = 1'b1; D_REQ = 1'b1; D_WE = 1'b1; D_BE = 4'hF;
    I_ADDR = 32'h44; D_ADDR = 32'h88; D_WDATA = 32'hA5A5A5A5;
    @(negedge CLK);
    n_checks++; if (I_GNT !== 1'b0) begin n_fails++; $display("FAIL rst_i_gnt: got %b want 0", I_GNT); end
    n_checks++; if (D_GNT !== 1'b0) begin n_fails++; $display("FAIL rst_d_gnt: got %b want 0", D_GNT); end
    n_checks++; if (MEM_CSN !== 1'b1) begin n_fails++; $display("FAIL rst_csn: got %b want 1", MEM_CSN); end
    n_checks++; if (MEM_WEN !== 1'b1) begin n_fails++; $display("FAIL rst_wen: got %b want 1", MEM_WEN); end
    n_checks++; if (MEM_BE !== 4'h0) begin n_fails++; $display("FAIL rst_be: got %h want 0", MEM_BE); end
    n_checks++; if (MEM_ADDR !== '0) begin n_fails++; $display("FAIL rst_addr: got %h want 0", MEM_ADDR); end
    n_checks++; if (MEM_DI !== 32'h0) begin n_fails++; $display("FAIL rst_di: got %h want 0", MEM_DI); end
    n_checks++; if ({I_RVALID, D_RVALID} !== 2'b00) begin n_fails++; $display("FAIL rst_rvalid: got %b want 00", {I_RVALID, D_RVALID}); end
    n_checks++; if ({I_RDATA, D_RDATA} !== 64'h0) begin n_fails++; $display("FAIL rst_rdata: got %h want 0", {I_RDATA, D_RDATA}); end
`ifdef UNIFIED_MEM_ARB_PERF_EN
    n_checks++; if (dut.perf_i_grants !== 32'd0) begin n_fails++; $display("FAIL rst_perf: got %0d want 0", dut.perf_i_grants); end
`endif
    tick();
    idle_inputs();
    RST = 1'b0;
    @(negedge CLK);
    n_checks++; if (MEM_CSN !== 1'b1) begin n_fails++; $display("FAIL idle_csn: got %b want 1", MEM_CSN); end
    tick();
  endtask

  task automatic test_fetch();
    sram[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    I_REQ = 1'b1; I_ADDR = 32'h40;
    @(negedge CLK);
    n_checks++; if ({I_GNT, D_GNT} !== 2'b10) begin n_fails++; $display("FAIL fetch_gnt: got %b want 10", {I_GNT, D_GNT}); end
    n_checks++; if ({MEM_CSN, MEM_WEN, MEM_BE} !== 6'b010000) begin n_fails++; $display("FAIL fetch_ctl: got %b want 010000", {MEM_CSN, MEM_WEN, MEM_BE}); end
    n_checks++; if (MEM_ADDR !== 12'h010) begin n_fails++; $display("FAIL fetch_addr: got %h want 010", MEM_ADDR); end
    tick();
    I_REQ = 1'b0;
    @(negedge CLK);
    n_checks++; if (I_RVALID !== 1'b1) begin n_fails++; $display("FAIL fetch_rvalid: got %b want 1", I_RVALID); end
    n_checks++; if (I_RDATA !== 32'hDEADBEEF) begin n_fails++; $display("FAIL fetch_rdata: got %h want deadbeef", I_RDATA); end
    n_checks++; if (D_RVALID !== 1'b0) begin n_fails++; $display("FAIL fetch_d_rvalid: got %b want 0", D_RVALID); end
    tick();
    @(negedge CLK);
    n_checks++; if (I_RVALID !== 1'b0) begin n_fails++; $display("FAIL fetch_rvalid_drop: got %b want 0", I_RVALID); end
    tick();
  endtask

  task automatic test_write_read();
    sram[32] = 32'hFFFFFFFF; ref_mem[32] = 32'hFFFFFFFF;
    D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h80; D_BE = 4'b0011; D_WDATA = 32'h12345678;
    @(negedge CLK);
    n_checks++; if ({I_GNT, D_GNT} !== 2'b01) begin n_fails++; $display("FAIL wr_gnt: got %b want 01", {I_GNT, D_GNT}); end
    n_checks++; if ({MEM_CSN, MEM_WEN, MEM_BE} !== 6'b000011) begin n_fails++; $display("FAIL wr_ctl: got %b want 000011", {MEM_CSN, MEM_WEN, MEM_BE}); end
    n_checks++; if (MEM_DI !== 32'h12345678) begin n_fails++; $display("FAIL wr_di: got %h want 12345678", MEM_DI); end
    n_checks++; if (MEM_ADDR !== 12'h020) begin n_fails++; $display("FAIL wr_addr: got %h want 020", MEM_ADDR); end
    tick();
    ref_mem[32] = 32'hFFFF5678;
    D_WE = 1'b0;
    @(negedge CLK);
    n_checks++; if (D_RVALID !== 1'b0) begin n_fails++; $display("FAIL wr_no_rvalid: got %b want 0", D_RVALID); end
    n_checks++; if ({D_GNT, MEM_WEN} !== 2'b11) begin n_fails++; $display("FAIL rd_gnt: got %b want 11", {D_GNT, MEM_WEN}); end
    tick();
    D_REQ = 1'b0;
    @(negedge CLK);
    n_checks++; if (D_RVALID !== 1'b1) begin n_fails++; $display("FAIL rd_rvalid: got %b want 1", D_RVALID); end
    n_checks++; if (D_RDATA !== 32'hFFFF5678) begin n_fails++; $display("FAIL rd_rdata: got %h want ffff5678", D_RDATA); end
    n_checks++; if (I_RVALID !== 1'b0) begin n_fails++; $display("FAIL rd_i_rvalid: got %b want 0", I_RVALID); end
    tick();
  endtask

  task automatic test_streak();
    logic exp_i, exp_iv, exp_dv;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    I_REQ = 1'b1; D_REQ = 1'b1; D_WE = 1'b0; I_ADDR = 32'h100; D_ADDR = 32'h200;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      exp_i  = (k % 5 == 4);
      exp_iv = (k >= 5) && (k % 5 == 0);
      exp_dv = (k > 0) && !exp_iv;
      n_checks++; if ({I_GNT, D_GNT} !== {exp_i, !exp_i}) begin n_fails++; $display("FAIL streak_gnt[%0d]: got %b want %b", k, {I_GNT, D_GNT}, {exp_i, !exp_i}); end
      n_checks++; if ({I_RVALID, D_RVALID} !== {exp_iv, exp_dv}) begin n_fails++; $display("FAIL streak_rvalid[%0d]: got %b want %b", k, {I_RVALID, D_RVALID}, {exp_iv, exp_dv}); end
      if (exp_iv) begin
        n_checks++; if (I_RDATA !== ref_mem[12'h040]) begin n_fails++; $display("FAIL streak_idata[%0d]: got %h want %h", k, I_RDATA, ref_mem[12'h040]); end
      end
`ifdef UNIFIED_MEM_ARB_PERF_EN
      if (k == 10) begin
        n_checks++; if (dut.perf_d_grants !== 32'd8) begin n_fails++; $display("FAIL perf_d_grants: got %0d want 8", dut.perf_d_grants); end
        n_checks++; if (dut.perf_i_grants !== 32'd2) begin n_fails++; $display("FAIL perf_i_grants: got %0d want 2", dut.perf_i_grants); end
        n_checks++; if (dut.perf_i_stalls !== 32'd8) begin n_fails++; $display("FAIL perf_i_stalls: got %0d want 8", dut.perf_i_stalls); end
      end
`endif
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_alternate();
    logic        prev_d;
    logic [31:0] prev_data;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        I_REQ = 1'b0; D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h400 + 32'(k * 4);
      end else begin
        D_REQ = 1'b0; I_REQ = 1'b1; I_ADDR = 32'h800 + 32'(k * 4);
      end
      @(negedge CLK);
      n_checks++; if (MEM_CSN !== 1'b0) begin n_fails++; $display("FAIL alt_csn[%0d]: got %b want 0", k, MEM_CSN); end
      if (k > 0) begin
        n_checks++; if ({I_RVALID, D_RVALID} !== {!prev_d, prev_d}) begin n_fails++; $display("FAIL alt_rvalid[%0d]: got %b want %b", k, {I_RVALID, D_RVALID}, {!prev_d, prev_d}); end
        n_checks++; if ((prev_d ? D_RDATA : I_RDATA) !== prev_data) begin n_fails++; $display("FAIL alt_rdata[%0d]: got %h want %h", k, prev_d ? D_RDATA : I_RDATA, prev_data); end
      end
      prev_d    = (k % 2 == 0);
      prev_data = prev_d ? ref_mem[D_ADDR[AW+1:2]] : ref_mem[I_ADDR[AW+1:2]];
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    I_REQ = 1'b1; I_ADDR = 32'h40;
    @(negedge CLK);
    n_checks++; if (I_GNT !== 1'b1) begin n_fails++; $display("FAIL mid_pre_gnt: got %b want 1", I_GNT); end
    tick();
    RST = 1'b1; D_REQ = 1'b1;
    @(negedge CLK);
    n_checks++; if (I_RVALID !== 1'b0) begin n_fails++; $display("FAIL mid_rvalid: got %b want 0", I_RVALID); end
    n_checks++; if ({MEM_CSN, I_GNT, D_GNT} !== 3'b100) begin n_fails++; $display("FAIL mid_idle: got %b want 100", {MEM_CSN, I_GNT, D_GNT}); end
    tick();
    RST = 1'b0; D_REQ = 1'b0;
    @(negedge CLK);
    n_checks++; if (I_GNT !== 1'b1) begin n_fails++; $display("FAIL post_rst_gnt: got %b want 1", I_GNT); end
    tick();
    I_REQ = 1'b0;
    @(negedge CLK);
    n_checks++; if ({I_RVALID, I_RDATA} !== {1'b1, ref_mem[12'h010]}) begin n_fails++; $display("FAIL post_rst_data: got %b/%h want 1/%h", I_RVALID, I_RDATA, ref_mem[12'h010]); end
    tick();
    // Build up a data streak, reset, then expect a full fresh streak.
    I_REQ = 1'b1; D_REQ = 1'b1; D_WE = 1'b0; I_ADDR = 32'h40; D_ADDR = 32'h80;
    repeat (3) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      n_checks++; if (I_GNT !== (k == 4)) begin n_fails++; $display("FAIL rst_streak[%0d]: got %b want %b", k, I_GNT, k == 4); end
      tick();
    end
    idle_inputs();
    repeat (2) tick();
  endtask

  task automatic test_random();
    int          streak = 0;
    logic        i_done = 1'b1, d_done = 1'b1, exp_i, exp_d;
    logic        pend_i = 1'b0, pend_d = 1'b0;
    logic [31:0] pend_idata = '0, pend_ddata = '0;
    logic [AW-1:0] widx;
    for (int n = 0; n < 600; n++) begin
      if (!I_REQ || i_done) begin
        I_REQ = ($urandom_range(0, 3) != 0); I_ADDR = $urandom;
      end
      if (!D_REQ || d_done) begin
        D_REQ = ($urandom_range(0, 2) != 0); D_WE = 1'($urandom); D_BE = 4'($urandom);
        D_ADDR = $urandom; D_WDATA = $urandom;
      end
      @(negedge CLK);
      exp_d = D_REQ && !(I_REQ && streak >= MAX);
      exp_i = I_REQ && !exp_d;
      n_checks++; if ({I_GNT, D_GNT, MEM_CSN} !== {exp_i, exp_d, !(exp_i || exp_d)}) begin n_fails++; $display("FAIL rnd_gnt[%0d]: got %b want %b", n, {I_GNT, D_GNT, MEM_CSN}, {exp_i, exp_d, !(exp_i || exp_d)}); end
      n_checks++; if ({I_RVALID, D_RVALID} !== {pend_i, pend_d}) begin n_fails++; $display("FAIL rnd_rvalid[%0d]: got %b want %b", n, {I_RVALID, D_RVALID}, {pend_i, pend_d}); end
      if (pend_i) begin
        n_checks++; if (I_RDATA !== pend_idata) begin n_fails++; $display("FAIL rnd_idata[%0d]: got %h want %h", n, I_RDATA, pend_idata); end
      end
      if (pend_d) begin
        n_checks++; if (D_RDATA !== pend_ddata) begin n_fails++; $display("FAIL rnd_ddata[%0d]: got %h want %h", n, D_RDATA, pend_ddata); end
      end
      pend_i = exp_i;
      pend_idata = ref_mem[I_ADDR[AW+1:2]];
      pend_d = exp_d && !D_WE;
      pend_ddata = ref_mem[D_ADDR[AW+1:2]];
      if (exp_d && D_WE) begin
        widx = D_ADDR[AW+1:2];
        for (int b = 0; b < 4; b++)
          if (D_BE[b]) ref_mem[widx][b*8 +: 8] = D_WDATA[b*8 +: 8];
      end
      if (!I_REQ || exp_i) streak = 0;
      else if (exp_d && streak < MAX) streak++;
      i_done = exp_i;
      d_done = exp_d;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    test_reset();
    test_fetch();
    test_write_read();
    test_streak();
    test_alternate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
